// File: rtl/demux4_pkg.sv
// Shared definitions for the registered 1-to-4 result distributor.
// Channel codes follow the logic-unit {S2,S3} select encoding.
package demux4_pkg;

    localparam int N_CH = 4;

    localparam logic [1:0] CH_A = 2'b00;
    localparam logic [1:0] CH_B = 2'b01;
    localparam logic [1:0] CH_C = 2'b10;
    localparam logic [1:0] CH_D = 2'b11;

    function automatic logic [N_CH-1:0] sel_to_onehot(input logic [1:0] sel);
        logic [N_CH-1:0] one;
        one = {{(N_CH-1){1'b0}}, 1'b1};
        return one << sel;
    endfunction

endpackage

// File: rtl/demux4_slot.sv
// One-entry valid/ready output register for a single distributor channel.
// With DEMUX4_CNT_EN defined it also counts completed drains (wrapping).
module demux4_slot #(
    parameter int WIDTH = 8
`ifdef DEMUX4_CNT_EN
   ,parameter int CNT_W = 8
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fill,
    input  logic [WIDTH-1:0] fill_data,
    output logic             can_fill,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    input  logic             ready
`ifdef DEMUX4_CNT_EN
   ,output logic [CNT_W-1:0] cnt
`endif
);

    logic drain;

    assign drain    = valid && ready;
    // A full slot can take a new word only in the cycle its current word leaves
    assign can_fill = !valid || ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (fill) begin
            valid <= 1'b1;
            data  <= fill_data;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

`ifdef DEMUX4_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (drain) begin
            cnt <= cnt + 1'b1;
        end
    end
`endif

endmodule

// File: rtl/demux4_reg.sv
// Registered 1-to-4 result distributor steering each accepted word to channel {S2,S3}.
// Optional per-channel drain counters are enabled with DEMUX4_CNT_EN.
module demux4_reg
    import demux4_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              S2,
    input  logic              S3,
    output logic [WIDTH-1:0]  out_a,
    output logic [WIDTH-1:0]  out_b,
    output logic [WIDTH-1:0]  out_c,
    output logic [WIDTH-1:0]  out_d,
    output logic [N_CH-1:0]   out_valid,
    input  logic [N_CH-1:0]   out_ready
`ifdef DEMUX4_CNT_EN
   ,output logic [N_CH*CNT_W-1:0] xfer_cnt
`endif
);

    logic [1:0]       idx;
    logic [N_CH-1:0]  sel_onehot;
    logic [N_CH-1:0]  can_fill;
    logic [N_CH-1:0]  fill;
    logic             accept;
    logic [WIDTH-1:0] slot_data [N_CH];

    assign idx        = {S2, S3};
    assign sel_onehot = sel_to_onehot(idx);
    // Only the targeted channel decides back-pressure; other empty channels do not help
    assign in_ready   = !rst && can_fill[idx];
    assign accept     = in_valid && in_ready;
    assign fill       = accept ? sel_onehot : '0;

    for (genvar g = 0; g < N_CH; g++) begin : g_slot
        demux4_slot #(
            .WIDTH(WIDTH)
`ifdef DEMUX4_CNT_EN
           ,.CNT_W(CNT_W)
`endif
        ) u_slot (
            .clk      (clk),
            .rst      (rst),
            .fill     (fill[g]),
            .fill_data(in_data),
            .can_fill (can_fill[g]),
            .data     (slot_data[g]),
            .valid    (out_valid[g]),
            .ready    (out_ready[g])
`ifdef DEMUX4_CNT_EN
           ,.cnt      (xfer_cnt[g*CNT_W +: CNT_W])
`endif
        );
    end

    assign out_a = slot_data[CH_A];
    assign out_b = slot_data[CH_B];
    assign out_c = slot_data[CH_C];
    assign out_d = slot_data[CH_D];

endmodule
